// File: rtl/rom_seq_reader_if.sv
// ROM read port plus valid/ready output stream of rom_seq_reader.
// The master side drives the ROM address/enable and sources the stream.
interface rom_seq_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) ();
    logic              rom_en;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output rom_en, rom_address, out_data, out_valid, out_last,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_en, rom_address, out_data, out_valid, out_last,
        output rom_data, out_ready
    );
endinterface

// File: rtl/rom_seq_reader.sv
// Sequential ROM read initiator: issues one address per cycle, buffers data in a FIFO.
// Define ROM_READER_WRAP_EN to wrap addresses instead of truncating at the top address.
module rom_seq_reader #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              truncated,
    rom_seq_reader_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
    localparam logic [OCC_W-1:0]  OCC_LIMIT = OCC_W'(FIFO_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              truncated_q, truncated_d;
    logic              trunc_pend_q, trunc_pend_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              rom_last_q, rom_last_d;
    logic              cap_pend_q, cap_pend_d;
    logic              cap_last_q, cap_last_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
    logic              mem_last_q [FIFO_DEPTH];
    logic              mem_last_d [FIFO_DEPTH];

    logic              out_valid_w;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;
    logic              issue_ok;
    logic              last_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_valid_w = (fifo_cnt_q != '0);
    assign push        = cap_pend_q;
    assign pop         = out_valid_w & bus.out_ready;

    // Words already buffered plus both pipeline stages must fit; a same-cycle pop is ignored.
    assign occupancy = OCC_W'(fifo_cnt_q) + OCC_W'(rom_en_q) + OCC_W'(cap_pend_q);
    assign issue_ok  = (occupancy < OCC_LIMIT);

`ifdef ROM_READER_WRAP_EN
    assign last_word = (remaining_q == REM_ONE);
`else
    assign last_word = (remaining_q == REM_ONE) || (addr_q == ADDR_TOP);
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        truncated_d   = truncated_q;
        trunc_pend_d  = trunc_pend_q;
        rom_en_d      = 1'b0;
        rom_address_d = rom_address_q;
        rom_last_d    = 1'b0;
        cap_pend_d    = rom_en_q;
        cap_last_d    = rom_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    truncated_d = 1'b0;
                    if (count != '0) begin
                        addr_d       = start_addr;
                        remaining_d  = count;
                        busy_d       = 1'b1;
                        trunc_pend_d = 1'b0;
                        state_d      = S_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue_ok) begin
                    rom_en_d      = 1'b1;
                    rom_address_d = addr_q;
                    rom_last_d    = last_word;
                    addr_d        = addr_q + 1'b1;
                    remaining_d   = remaining_q - 1'b1;
`ifndef ROM_READER_WRAP_EN
                    if ((addr_q == ADDR_TOP) && (remaining_q != REM_ONE)) begin
                        trunc_pend_d = 1'b1;
                    end
`endif
                    if (last_word) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!rom_en_q && !cap_pend_q && (fifo_cnt_q == '0)) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    truncated_d = trunc_pend_q;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        mem_data_d = mem_data_q;
        mem_last_d = mem_last_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = bus.rom_data;
            mem_last_d[wr_ptr_q] = cap_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            truncated_q   <= 1'b0;
            trunc_pend_q  <= 1'b0;
            rom_en_q      <= 1'b0;
            rom_address_q <= '0;
            rom_last_q    <= 1'b0;
            cap_pend_q    <= 1'b0;
            cap_last_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            truncated_q   <= truncated_d;
            trunc_pend_q  <= trunc_pend_d;
            rom_en_q      <= rom_en_d;
            rom_address_q <= rom_address_d;
            rom_last_q    <= rom_last_d;
            cap_pend_q    <= cap_pend_d;
            cap_last_q    <= cap_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Storage is cleared on reset so the stream outputs read as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            mem_data_q <= mem_data_d;
            mem_last_q <= mem_last_d;
        end
    end

    assign bus.rom_en      = rom_en_q;
    assign bus.rom_address = rom_address_q;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_data    = mem_data_q[rd_ptr_q];
    assign bus.out_last    = out_valid_w & mem_last_q[rd_ptr_q];
    assign busy            = busy_q;
    assign done            = done_q;
    assign truncated       = truncated_q;
endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader against a behavioural ROM with mem[i] = i ^ 4'hA.
// Build with or without ROM_READER_WRAP_EN; the boundary expectations follow the macro.
module tb_rom_seq_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] count = '0;
    logic       busy;
    logic       done;
    logic       truncated;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    rom_seq_reader_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    rom_seq_reader #(.ADDR_W(4), .DATA_W(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .truncated  (truncated),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM, one-cycle latency.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= bus.rom_address ^ 4'hA;
    end

    logic [3:0] got_data [$];
    logic       got_last [$];
    int         got_cyc  [$];
    int issued = 0, popped = 0, max_out = 0, done_cnt = 0, busy_seen = 0, first_valid = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_en) issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
                popped++;
            end
            if (done) done_cnt++;
            if (busy) busy_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {busy, done, truncated, bus.rom_en, bus.rom_address,
                bus.out_data, bus.out_valid, bus.out_last};
    endfunction

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        issued = 0; popped = 0; max_out = 0;
        done_cnt = 0; busy_seen = 0; first_valid = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] a, input logic [4:0] c, output int e);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; count = c;
        @(posedge clk); #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output logic trunc_at, output int done_at);
        logic seen;
        seen = 1'b0; trunc_at = 1'b0; done_at = -1;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                trunc_at = truncated;
                done_at = cyc;
                chk({tag, "_busy_at_done"}, busy, 0);
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_words(input string tag, input logic [3:0] base, input int n);
        logic [3:0] a;
        chk({tag, "_nwords"}, got_data.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + 4'(i);
            if (i < got_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), got_data[i], a ^ 4'hA);
                chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == n - 1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   e, e2, dcyc;
        logic tr;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word
        bus.out_ready = 1'b1;
        clear_log();
        do_start(4'hC, 5'd1, e);
        wait_done("single", 20, tr, dcyc);
        idle(3);
        check_words("single", 4'hC, 1);
        chk("single_first_valid", first_valid, e + 3);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_busy_end", busy, 0);
        $display("xfer single addr=c count=1 words=%0d", got_data.size());

        // Full-rate burst
        clear_log();
        do_start(4'h0, 5'd16, e);
        wait_done("burst", 60, tr, dcyc);
        idle(3);
        check_words("burst", 4'h0, 16);
        if (got_cyc.size() == 16) begin
            chk("burst_rate", got_cyc[15] - got_cyc[0], 15);
            chk("burst_done_lag", dcyc, got_cyc[15] + 2);
        end
        chk("burst_first_valid", first_valid, e + 3);
        chk("burst_done_cnt", done_cnt, 1);
        $display("xfer burst addr=0 count=16 words=%0d", got_data.size());

        // Back-pressure
        bus.out_ready = 1'b0;
        clear_log();
        do_start(4'h3, 5'd8, e);
        idle(10);
        chk("bp_issued_stall", issued, 4);
        chk("bp_max_out", max_out, 4);
        chk("bp_no_pop", got_data.size(), 0);
        chk("bp_busy", busy, 1);
        bus.out_ready = 1'b1;
        wait_done("bp", 60, tr, dcyc);
        idle(3);
        check_words("bp", 4'h3, 8);
        chk("bp_max_out_end", max_out, 4);
        chk("bp_issued_total", issued, 8);
        $display("xfer backpressure addr=3 count=8 words=%0d", got_data.size());

        // Top-address boundary
        clear_log();
        do_start(4'hE, 5'd4, e);
        wait_done("bound", 40, tr, dcyc);
        idle(3);
`ifdef ROM_READER_WRAP_EN
        check_words("bound_wrap", 4'hE, 4);
        chk("bound_trunc", tr, 0);
`else
        check_words("bound_trunc", 4'hE, 2);
        chk("bound_trunc", tr, 1);
        chk("bound_trunc_held", truncated, 1);
`endif
        $display("xfer boundary addr=e count=4 words=%0d", got_data.size());

        // Zero count
        clear_log();
        do_start(4'h7, 5'd0, e);
        wait_done("zero", 5, tr, dcyc);
        idle(3);
        chk("zero_done_at", dcyc, e);
        chk("zero_issued", issued, 0);
        chk("zero_busy_seen", busy_seen, 0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_words", got_data.size(), 0);
        $display("xfer zero addr=7 count=0 words=%0d", got_data.size());

        // Start while busy is ignored
        clear_log();
        do_start(4'h5, 5'd6, e);
        do_start(4'h0, 5'd3, e2);
        wait_done("ign", 40, tr, dcyc);
        idle(4);
        check_words("ign", 4'h5, 6);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_issued", issued, 6);
        $display("xfer ignored_start addr=5 count=6 words=%0d", got_data.size());

        // Reset with three words buffered
        bus.out_ready = 1'b0;
        clear_log();
        do_start(4'h0, 5'd16, e);
        idle(5);
        chk("mid_busy_before", busy, 1);
        chk("mid_valid_before", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", all_outs(), 0);
        @(posedge clk); #1;
        chk("mid_rst_hold", all_outs(), 0);
        rst_n = 1'b1;
        $display("xfer reset_mid addr=0 count=16 words=%0d", got_data.size());

        bus.out_ready = 1'b1;
        clear_log();
        do_start(4'h2, 5'd3, e);
        wait_done("after_rst", 30, tr, dcyc);
        idle(3);
        check_words("after_rst", 4'h2, 3);
        chk("after_rst_done_cnt", done_cnt, 1);
        $display("xfer after_reset addr=2 count=3 words=%0d", got_data.size());

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
